// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: opcodes, FSM states, error rule.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_DIV  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } drv_state_t;

  // A command is in error when its opcode is reserved or it divides by zero.
  function automatic logic is_err(input logic [2:0] op, input logic [3:0] b);
    return (op == OP_RSVD) || ((op == OP_DIV) && (b == 4'd0));
  endfunction

endpackage

// File: rtl/alu_cmd_driver_sat_counter.sv
// Saturating up-counter with a synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count increments until all-ones, then holds; clear has priority.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Requester-side front end for the 4-bit ALU: accepts tagged commands, holds
// the ALU operands stable for a settle window, then returns the captured result.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int TAG_W         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [7:0]       alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [CNT_W-1:0] ops_done,
  output logic [CNT_W-1:0] err_count
);

  localparam int SET_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  drv_state_t       state;
  logic [SET_W-1:0] settle_cnt;
  logic             cmd_fire;
  logic             rsp_fire;

  // A new command can enter when idle, or when the pending response leaves this cycle.
  assign cmd_ready = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  // Main FSM: accept, settle-count, capture, then hold the response until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end
      if (cmd_fire) begin
        alu_a      <= cmd_a;
        alu_b      <= cmd_b;
        alu_opcode <= cmd_op;
        rsp_tag    <= cmd_tag;
        rsp_err    <= is_err(cmd_op, cmd_b);
        settle_cnt <= SET_W'(SETTLE_CYCLES);
        state      <= ST_WAIT;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_IDLE;
          end
          ST_WAIT: begin
            if (settle_cnt == SET_W'(1)) begin
              rsp_result <= rsp_err ? 8'h00 : alu_result;
              rsp_valid  <= 1'b1;
              state      <= ST_RESP;
            end else begin
              settle_cnt <= settle_cnt - SET_W'(1);
            end
          end
          ST_RESP: begin
            if (rsp_ready) begin
              state <= ST_IDLE;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_ops_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (rsp_fire),
    .count (ops_done)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (rsp_fire && rsp_err),
    .count (err_count)
  );

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: one instance with a 1-cycle settle and
// wide counters, one with a 3-cycle settle and 2-bit counters to reach saturation.
module tb_alu_cmd_driver;

  localparam int TAG_W  = 4;
  localparam int CNT1_W = 16;
  localparam int CNT3_W = 2;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid;
  logic rsp_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  logic cmd_ready1, rsp_valid1, rsp_err1;
  logic [3:0] alu_a1, alu_b1;
  logic [2:0] alu_op1;
  logic [7:0] alu_res1, rsp_result1;
  logic [TAG_W-1:0] rsp_tag1;
  logic [CNT1_W-1:0] ops1, errc1;

  logic cmd_ready3, rsp_valid3, rsp_err3;
  logic [3:0] alu_a3, alu_b3;
  logic [2:0] alu_op3;
  logic [7:0] alu_res3, rsp_result3;
  logic [TAG_W-1:0] rsp_tag3;
  logic [CNT3_W-1:0] ops3, errc3;

  int vectors = 0;
  int miscompares = 0;
  int exp_ops = 0;
  int exp_errs = 0;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Behavioural 4-bit ALU; div-by-zero and reserved return non-zero junk on purpose.
  function automatic logic [7:0] alu_eval(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] sa, sb;
    sa = {{4{a[3]}}, a};
    sb = {{4{b[3]}}, b};
    case (op)
      3'd0: return {4'h0, a + b};
      3'd1: return {4'h0, a - b};
      3'd2: return {4'h0, a & b};
      3'd3: return {4'h0, a | b};
      3'd4: return {4'h0, a ^ b};
      3'd5: return sa * sb;
      3'd6: return (b == 4'd0) ? 8'hFF : {4'h0, a / b};
      default: return 8'hA5;
    endcase
  endfunction

  function automatic logic ref_err(input logic [2:0] op, input logic [3:0] b);
    return (op == 3'd7) || (op == 3'd6 && b == 4'd0);
  endfunction

  function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    return ref_err(op, b) ? 8'h00 : alu_eval(op, a, b);
  endfunction

  assign alu_res1 = alu_eval(alu_op1, alu_a1, alu_b1);
  assign alu_res3 = alu_eval(alu_op3, alu_a3, alu_b3);

  alu_cmd_driver #(.TAG_W(TAG_W), .SETTLE_CYCLES(1), .CNT_W(CNT1_W)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_opcode(alu_op1), .alu_result(alu_res1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_result(rsp_result1),
    .rsp_tag(rsp_tag1), .rsp_err(rsp_err1), .ops_done(ops1), .err_count(errc1)
  );

  alu_cmd_driver #(.TAG_W(TAG_W), .SETTLE_CYCLES(3), .CNT_W(CNT3_W)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_opcode(alu_op3), .alu_result(alu_res3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_result(rsp_result3),
    .rsp_tag(rsp_tag3), .rsp_err(rsp_err3), .ops_done(ops3), .err_count(errc3)
  );

  // One command through dut1 with rsp_ready high, checking every step.
  task automatic do_cmd1(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] tag, input logic [7:0] exp_res, input logic exp_err);
    int n;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; rsp_ready = 1'b1;
    #1;
    n = 0;
    while (!cmd_ready1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (cmd_ready1 !== 1'b1) begin
      miscompares++; $display("[TB] FAIL cmd_accept_timeout: got cmd_ready=%b expected 1", cmd_ready1);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_tag = 4'($urandom);
    vectors++;
    if ({rsp_valid1, alu_a1, alu_b1, alu_op1} !== {1'b0, a, b, op}) begin
      miscompares++; $display("[TB] FAIL accept_regs: got %h expected %h", {rsp_valid1, alu_a1, alu_b1, alu_op1}, {1'b0, a, b, op});
    end
    @(posedge clk); #1;
    vectors++;
    if ({rsp_valid1, rsp_result1, rsp_tag1, rsp_err1} !== {1'b1, exp_res, tag, exp_err}) begin
      miscompares++; $display("[TB] FAIL response: got %h expected %h", {rsp_valid1, rsp_result1, rsp_tag1, rsp_err1}, {1'b1, exp_res, tag, exp_err});
    end
    @(posedge clk); #1;
    exp_ops++;
    if (exp_err) exp_errs++;
    vectors++;
    if (ops1 !== CNT1_W'(exp_ops) || errc1 !== CNT1_W'(exp_errs) || rsp_valid1 !== 1'b0) begin
      miscompares++; $display("[TB] FAIL counters: got ops=%0d errs=%0d valid=%b expected ops=%0d errs=%0d valid=0", ops1, errc1, rsp_valid1, exp_ops, exp_errs);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 3'd0; cmd_a = 4'd0; cmd_b = 4'd0; cmd_tag = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    vectors++;
    if ({alu_a1, alu_b1, alu_op1, rsp_valid1, rsp_result1, rsp_tag1, rsp_err1} !== '0) begin
      miscompares++; $display("[TB] FAIL reset_outputs1: got %h expected 0", {alu_a1, alu_b1, alu_op1, rsp_valid1, rsp_result1, rsp_tag1, rsp_err1});
    end
    vectors++;
    if (ops1 !== '0 || errc1 !== '0 || cmd_ready1 !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_counters1: got ops=%0d errs=%0d ready=%b expected 0 0 1", ops1, errc1, cmd_ready1);
    end
    vectors++;
    if ({alu_a3, alu_b3, alu_op3, rsp_valid3, rsp_result3, rsp_tag3, rsp_err3, ops3, errc3} !== '0) begin
      miscompares++; $display("[TB] FAIL reset_outputs3: got %h expected 0", {alu_a3, alu_b3, alu_op3, rsp_valid3, rsp_result3, rsp_tag3, rsp_err3, ops3, errc3});
    end
    exp_ops = 0; exp_errs = 0;
  endtask

  task automatic test_basic_ops;
    do_cmd1(3'd0, 4'd5, 4'd3, 4'd1, 8'h08, 1'b0);
    vectors++;
    if (ops1 !== 16'd1) begin
      miscompares++; $display("[TB] FAIL ops_after_add: got %0d expected 1", ops1);
    end
    do_cmd1(3'd1, 4'd3, 4'd5, 4'd2, 8'h0E, 1'b0);
    do_cmd1(3'd5, 4'd3, 4'hE, 4'd3, 8'hFA, 1'b0);
    do_cmd1(3'd6, 4'd13, 4'd4, 4'd4, 8'h03, 1'b0);
    vectors++;
    if (ops1 !== 16'd4 || errc1 !== 16'd0) begin
      miscompares++; $display("[TB] FAIL ops_after_basic: got ops=%0d errs=%0d expected 4 0", ops1, errc1);
    end
  endtask

  task automatic test_errors;
    do_cmd1(3'd6, 4'd9, 4'd0, 4'd5, 8'h00, 1'b1);
    do_cmd1(3'd7, 4'd1, 4'd1, 4'd6, 8'h00, 1'b1);
    vectors++;
    if (errc1 !== 16'd2) begin
      miscompares++; $display("[TB] FAIL err_count: got %0d expected 2", errc1);
    end
  endtask

  task automatic test_backpressure;
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 4'd2; cmd_b = 4'd2; cmd_tag = 4'd5; rsp_ready = 1'b0;
    #1;
    vectors++;
    if (cmd_ready1 !== 1'b1) begin
      miscompares++; $display("[TB] FAIL bp_idle_ready: got %b expected 1", cmd_ready1);
    end
    @(posedge clk); #1;
    cmd_op = 3'd4; cmd_a = 4'hA; cmd_b = 4'h5; cmd_tag = 4'd6;
    vectors++;
    if (cmd_ready1 !== 1'b0) begin
      miscompares++; $display("[TB] FAIL bp_wait_ready: got %b expected 0", cmd_ready1);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({rsp_valid1, rsp_result1, rsp_tag1, rsp_err1, cmd_ready1} !== {1'b1, 8'h04, 4'd5, 1'b0, 1'b0}) begin
        miscompares++; $display("[TB] FAIL bp_hold: got %h expected %h", {rsp_valid1, rsp_result1, rsp_tag1, rsp_err1, cmd_ready1}, {1'b1, 8'h04, 4'd5, 1'b0, 1'b0});
      end
      vectors++;
      if ({alu_a1, alu_b1, alu_op1} !== {4'd2, 4'd2, 3'd0}) begin
        miscompares++; $display("[TB] FAIL bp_alu_stable: got %h expected %h", {alu_a1, alu_b1, alu_op1}, {4'd2, 4'd2, 3'd0});
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1; #1;
    vectors++;
    if (cmd_ready1 !== 1'b1) begin
      miscompares++; $display("[TB] FAIL bp_release_ready: got %b expected 1", cmd_ready1);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    exp_ops++;
    vectors++;
    if ({rsp_valid1, alu_a1, alu_b1, alu_op1} !== {1'b0, 4'hA, 4'h5, 3'd4} || ops1 !== CNT1_W'(exp_ops)) begin
      miscompares++; $display("[TB] FAIL bp_same_edge_accept: got %h ops=%0d expected %h ops=%0d", {rsp_valid1, alu_a1, alu_b1, alu_op1}, ops1, {1'b0, 4'hA, 4'h5, 3'd4}, exp_ops);
    end
    @(posedge clk); #1;
    vectors++;
    if ({rsp_valid1, rsp_result1, rsp_tag1, rsp_err1} !== {1'b1, 8'h0F, 4'd6, 1'b0}) begin
      miscompares++; $display("[TB] FAIL bp_second_rsp: got %h expected %h", {rsp_valid1, rsp_result1, rsp_tag1, rsp_err1}, {1'b1, 8'h0F, 4'd6, 1'b0});
    end
    @(posedge clk); #1;
    exp_ops++;
    vectors++;
    if (ops1 !== CNT1_W'(exp_ops) || rsp_valid1 !== 1'b0) begin
      miscompares++; $display("[TB] FAIL bp_final: got ops=%0d valid=%b expected ops=%0d valid=0", ops1, rsp_valid1, exp_ops);
    end
  endtask

  task automatic test_random;
    logic [12:0] q[$];
    logic [12:0] exp;
    logic acc, rhs;
    int nresp;
    nresp = 0;
    for (int cyc = 0; cyc < 320; cyc++) begin
      cmd_valid = (cyc < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_op = 3'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_tag = 4'($urandom);
      if (cmd_op == 3'd6 && $urandom_range(0, 3) == 0) cmd_b = 4'd0;
      rsp_ready = (cyc < 300) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      acc = cmd_valid && cmd_ready1;
      rhs = rsp_valid1 && rsp_ready;
      if (rhs) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++; $display("[TB] FAIL rand_unexpected_rsp: got tag %h expected no response", rsp_tag1);
        end else begin
          exp = q.pop_front();
          nresp++;
          exp_ops++;
          if (exp[0]) exp_errs++;
          if ({rsp_result1, rsp_tag1, rsp_err1} !== exp) begin
            miscompares++; $display("[TB] FAIL rand_rsp: got %h expected %h", {rsp_result1, rsp_tag1, rsp_err1}, exp);
          end
        end
      end
      if (acc) q.push_back({ref_result(cmd_op, cmd_a, cmd_b), cmd_tag, ref_err(cmd_op, cmd_b)});
      @(posedge clk); #1;
    end
    vectors++;
    if (q.size() != 0 || nresp < 20) begin
      miscompares++; $display("[TB] FAIL rand_drain: got pending=%0d responses=%0d expected pending=0 responses>=20", q.size(), nresp);
    end
    vectors++;
    if (ops1 !== CNT1_W'(exp_ops) || errc1 !== CNT1_W'(exp_errs)) begin
      miscompares++; $display("[TB] FAIL rand_counters: got ops=%0d errs=%0d expected ops=%0d errs=%0d", ops1, errc1, exp_ops, exp_errs);
    end
  endtask

  task automatic test_reset_inflight;
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_a = 4'd7; cmd_b = 4'd7; cmd_tag = 4'hC; rsp_ready = 1'b1;
    #1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; rst = 1'b1;
    vectors++;
    if (rsp_valid1 !== 1'b0 || alu_a1 !== 4'd7) begin
      miscompares++; $display("[TB] FAIL rst_pre_wait: got valid=%b alu_a=%h expected 0 7", rsp_valid1, alu_a1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({alu_a1, alu_b1, alu_op1, rsp_valid1, rsp_result1, rsp_tag1, rsp_err1, ops1, errc1} !== '0) begin
      miscompares++; $display("[TB] FAIL rst_inflight_clear: got %h expected 0", {alu_a1, alu_b1, alu_op1, rsp_valid1, rsp_result1, rsp_tag1, rsp_err1, ops1, errc1});
    end
    @(posedge clk); #1;
    vectors++;
    if (rsp_valid1 !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rst_no_pulse: got %b expected 0", rsp_valid1);
    end
    exp_ops = 0; exp_errs = 0;
    do_cmd1(3'd1, 4'h9, 4'h2, 4'h7, 8'h07, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [2:0]  ops[4];
    logic [3:0]  as[4];
    logic [3:0]  bs[4];
    logic [12:0] expq[4];
    logic acc;
    int k, nrsp, cyc, last, nerr;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nerr = 0;
    for (int i = 0; i < 4; i++) begin
      ops[i] = 3'($urandom); as[i] = 4'($urandom); bs[i] = 4'($urandom);
      expq[i] = {ref_result(ops[i], as[i], bs[i]), 4'(9 + i), ref_err(ops[i], bs[i])};
      if (expq[i][0]) nerr++;
    end
    k = 0; nrsp = 0; cyc = 0; last = 0;
    cmd_valid = 1'b1; cmd_op = ops[0]; cmd_a = as[0]; cmd_b = bs[0]; cmd_tag = 4'd9;
    while (nrsp < 4 && cyc < 80) begin
      #1;
      if (rsp_valid3) begin
        vectors++;
        if ({rsp_result3, rsp_tag3, rsp_err3} !== expq[nrsp]) begin
          miscompares++; $display("[TB] FAIL b2b_rsp%0d: got %h expected %h", nrsp, {rsp_result3, rsp_tag3, rsp_err3}, expq[nrsp]);
        end
        if (nrsp > 0) begin
          vectors++;
          if (cyc - last != 4) begin
            miscompares++; $display("[TB] FAIL b2b_spacing: got %0d expected 4", cyc - last);
          end
        end
        last = cyc;
        nrsp++;
      end else if (k > 0) begin
        vectors++;
        if ({alu_a3, alu_b3, alu_op3} !== {as[k-1], bs[k-1], ops[k-1]}) begin
          miscompares++; $display("[TB] FAIL b2b_alu_stable: got %h expected %h", {alu_a3, alu_b3, alu_op3}, {as[k-1], bs[k-1], ops[k-1]});
        end
      end
      acc = cmd_valid && cmd_ready3;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        k++;
        if (k < 4) begin
          cmd_op = ops[k]; cmd_a = as[k]; cmd_b = bs[k]; cmd_tag = 4'(9 + k);
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    vectors++;
    if (nrsp != 4) begin
      miscompares++; $display("[TB] FAIL b2b_timeout: got %0d responses expected 4", nrsp);
    end
    vectors++;
    if (ops3 !== 2'd3 || errc3 !== CNT3_W'((nerr > 3) ? 3 : nerr)) begin
      miscompares++; $display("[TB] FAIL b2b_saturation: got ops=%0d errs=%0d expected ops=3 errs=%0d", ops3, errc3, (nerr > 3) ? 3 : nerr);
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    test_reset();
    test_basic_ops();
    test_errors();
    test_backpressure();
    test_random();
    test_reset_inflight();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case a scenario never returns.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
